inverter: RTL and testbench

INVERTER -- requirements
Module: inverter

---
 rtl/inverter.sv | 78 +++++++
 tb/tb_inverter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/inverter.sv
`default_nettype none
// ============================================================================
// Module   : inverter
// Brief    : Combinational bitwise inverter with input sampling, saturating
//            toggle counter and registered idle detector.
// Revision : 1.0 - initial release
// ============================================================================
module inverter #(
    parameter int WIDTH      = 1,
    parameter int CNT_W      = 16,
    parameter int IDLE_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             idle,
    output logic [WIDTH-1:0] sample
);

    localparam int                    c_IDLE_W   = $clog2(IDLE_LIMIT + 1);
    localparam logic [c_IDLE_W-1:0]   c_IDLE_MAX = c_IDLE_W'(IDLE_LIMIT);
    localparam logic [CNT_W-1:0]      c_CNT_MAX  = {CNT_W{1'b1}};

    logic [WIDTH-1:0]    r_sample;
    logic [CNT_W-1:0]    r_toggle_cnt;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                r_idle;

    logic                w_toggle;
    logic [CNT_W-1:0]    w_toggle_cnt_nxt;
    logic [c_IDLE_W-1:0] w_idle_cnt_nxt;

    // The data path is a straight inversion; no register or reset touches it.
    assign y = ~a;

    // Any number of bits changing in one sampled cycle is a single toggle.
    assign w_toggle = (a != r_sample);

    always_comb begin
        w_toggle_cnt_nxt = r_toggle_cnt;
        if (w_toggle && (r_toggle_cnt != c_CNT_MAX)) begin
            w_toggle_cnt_nxt = r_toggle_cnt + 1'b1;
        end
    end

    always_comb begin
        w_idle_cnt_nxt = r_idle_cnt;
        if (w_toggle) begin
            w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt != c_IDLE_MAX) begin
            w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end
    end

    // idle is registered from the next-state count so it tracks r_idle_cnt
    // on the same cycle without an extra stage of lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample     <= '0;
            r_toggle_cnt <= '0;
            r_idle_cnt   <= '0;
            r_idle       <= 1'b0;
        end else begin
            r_sample     <= a;
            r_toggle_cnt <= w_toggle_cnt_nxt;
            r_idle_cnt   <= w_idle_cnt_nxt;
            r_idle       <= (w_idle_cnt_nxt == c_IDLE_MAX);
        end
    end

    assign sample     = r_sample;
    assign toggle_cnt = r_toggle_cnt;
    assign idle       = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_inverter.sv
`default_nettype none
// ============================================================================
// Module   : tb_inverter
// Brief    : Directed plus randomized self-checking bench for inverter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inverter;

    localparam int c_WIDTH = 8;
    localparam int c_CNT_W = 4;
    localparam int c_IDLE  = 8;
    localparam int c_CMAX  = (1 << c_CNT_W) - 1;

    logic               clk;
    logic               rst;
    logic [c_WIDTH-1:0] a;
    logic [c_WIDTH-1:0] y;
    logic [c_CNT_W-1:0] toggle_cnt;
    logic               idle;
    logic [c_WIDTH-1:0] sample;

    logic        a1;
    logic        y1;
    logic [15:0] toggle_cnt1;
    logic        idle1;
    logic        sample1;

    int n_cmp;
    int n_bad;

    // Reference state, kept as plain integers.
    int m_sample;
    int m_cnt;
    int m_run;
    int m_idle;

    inverter #(.WIDTH(c_WIDTH), .CNT_W(c_CNT_W), .IDLE_LIMIT(c_IDLE)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .y          (y),
        .toggle_cnt (toggle_cnt),
        .idle       (idle),
        .sample     (sample)
    );

    inverter #(.WIDTH(1), .CNT_W(16), .IDLE_LIMIT(1024)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .a          (a1),
        .y          (y1),
        .toggle_cnt (toggle_cnt1),
        .idle       (idle1),
        .sample     (sample1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: check y before the edge, advance the model, check registers after.
    task automatic step(input logic [c_WIDTH-1:0] v, input logic r);
        a   = v;
        rst = r;
        #1;
        check("y_comb", 32'(y), 32'((~int'(v)) & 'hFF));
        @(posedge clk);
        if (r) begin
            m_sample = 0;
            m_cnt    = 0;
            m_run    = 0;
            m_idle   = 0;
        end else begin
            if (int'(v) != m_sample) begin
                m_cnt = (m_cnt < c_CMAX) ? m_cnt + 1 : c_CMAX;
                m_run = 0;
            end else begin
                m_run = (m_run < c_IDLE) ? m_run + 1 : c_IDLE;
            end
            m_idle   = (m_run == c_IDLE) ? 1 : 0;
            m_sample = int'(v);
        end
        #1;
        check("sample", 32'(sample), 32'(m_sample));
        check("toggle_cnt", 32'(toggle_cnt), 32'(m_cnt));
        check("idle", 32'(idle), 32'(m_idle));
    endtask

    initial begin
        logic [c_WIDTH-1:0] v;
        int hold;
        n_cmp = 0;
        n_bad = 0;
        a     = '0;
        a1    = 1'b0;
        rst   = 1'b1;

        // Reset with changing input: y follows, registers clear.
        step(8'h00, 1'b1);
        step(8'h3C, 1'b1);
        step(8'h00, 1'b1);

        // Single-bit instance is purely combinational, checked between edges.
        a1 = 1'b0;
        #1;
        check("y1_a0", 32'(y1), 32'd1);
        a1 = 1'b1;
        #1;
        check("y1_a1", 32'(y1), 32'd0);

        // First edge after reset compares against zero.
        step(8'hA5, 1'b0);
        check("a5_sample", 32'(sample), 32'hA5);
        check("a5_cnt", 32'(toggle_cnt), 32'd1);

        // Ten toggles after reset, then continue into saturation.
        step(8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 8'hFF : 8'h0F, 1'b0);
        check("ten_cnt", 32'(toggle_cnt), 32'd10);
        check("ten_idle", 32'(idle), 32'd0);
        for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 8'hFF : 8'h0F, 1'b0);
        check("sat_cnt", 32'(toggle_cnt), 32'd15);

        // Idle rises after IDLE_LIMIT quiet cycles, one toggle drops it.
        step(8'h00, 1'b1);
        step(8'h11, 1'b0);
        for (int i = 0; i < c_IDLE - 1; i++) step(8'h11, 1'b0);
        check("idle_pre", 32'(idle), 32'd0);
        step(8'h11, 1'b0);
        check("idle_rise", 32'(idle), 32'd1);
        step(8'h11, 1'b0);
        step(8'h12, 1'b0);
        check("idle_drop", 32'(idle), 32'd0);

        // Reset mid-count wins over a simultaneous toggle.
        step(8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(8'(i + 1), 1'b0);
        check("five_cnt", 32'(toggle_cnt), 32'd5);
        step(8'hC3, 1'b1);
        check("rst_cnt", 32'(toggle_cnt), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);
        check("rst_y", 32'(y), 32'h3C);

        // Randomized bursts with variable hold lengths and occasional reset.
        for (int b = 0; b < 40; b++) begin
            v    = 8'($urandom);
            hold = int'($urandom_range(0, 12));
            step(v, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
            for (int h = 0; h < hold; h++) step(v, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
